fetch_ctrl: RTL and testbench

- Sequences instruction fetch between the PC register and the instruction-side SRAM-like bus (req/addr_ok/data_ok).
- Issues requests at the current PC and pulses the PC-advance enable on each address handshake.
- Tracks in-flight requests and buffers returned instructions until decode accepts them.
- Discards wrong-path responses after a pipeline kill (exception flush or taken-branch redirect).

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch
//               controller: the debug FSM encoding, the instruction FIFO
//               entry layout and the word used for faulted fetches.
//               Optional macro FETCH_ADEL_EN widens the FIFO entry with an
//               address-error bit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        adel;
   } fetch_entry_t;

   localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

`ifdef FETCH_ADEL_EN
   localparam int ENTRY_W = 65;
`else
   localparam int ENTRY_W = 64;
`endif

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Instruction-side SRAM-like bus (req/addr_ok/data_ok).
//               master : fetch controller (drives req/addr)
//               slave  : memory side   (drives addr_ok/data_ok/rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with synchronous clear and occupancy count.
//               Ports: clk, rst (async, active-low), clr_i (drops contents,
//               wins over push/pop), push_i/din_i, pop_i, dout_o (head),
//               count_o (entries held). DEPTH must be a power of two so the
//               pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      // A full FIFO can still take a push when the head leaves in the same cycle.
      do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer between the PC register and the
//               instruction SRAM-like bus. Issues requests at pc_i, pulses
//               pc_en_o on each address handshake, remembers the PC of every
//               in-flight request, buffers returned instructions for decode
//               and discards wrong-path responses after kill_i.
//               Ports: clk, rst (async, active-low), pc_i/pc_en_o (PC
//               register), kill_i, stall_i, bus (fetch_ctrl_if.master),
//               inst_valid_o/inst_o/inst_pc_o/inst_adel_o (to decode),
//               fetch_state_o (debug view of RUN/DRAIN).
//               Optional macro FETCH_ADEL_EN: misaligned PCs produce a
//               local address-error entry instead of a bus request.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         pc_i,
   output logic                pc_en_o,
   input  logic                kill_i,
   input  logic                stall_i,
   fetch_ctrl_if.master        bus,
   output logic                inst_valid_o,
   output logic [31:0]         inst_o,
   output logic [31:0]         inst_pc_o,
   output logic                inst_adel_o,
   output fetch_state_e        fetch_state_o
);

   logic [CNT_W-1:0]   out_cnt;       // in-flight requests == PC queue occupancy
   logic [CNT_W-1:0]   out_cnt_d;
   logic [CNT_W-1:0]   fifo_cnt;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   fetch_state_e       state_q, state_d;
   logic [CNT_W:0]     occupancy;
   logic               issue_room;
   logic               misaligned;
   logic               adel_push;
   logic               hs;
   logic               data_ok;
   logic               data_keep;
   logic [31:0]        pcq_head;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;
   fetch_entry_t       head_entry;

   // Requests plus buffered instructions share one budget so that every
   // accepted address is guaranteed a FIFO slot when its data returns.
   assign occupancy  = {1'b0, out_cnt} + {1'b0, fifo_cnt};
   assign issue_room = rst && (occupancy < (CNT_W+1)'(DEPTH));
   assign data_ok    = bus.inst_data_ok;

`ifdef FETCH_ADEL_EN
   assign misaligned = pc_i[1:0] != 2'b00;
   // The error entry must not overtake older fetches still on the bus.
   assign adel_push  = issue_room && misaligned && (out_cnt == '0)
                       && !data_ok && !kill_i;
`else
   assign misaligned = 1'b0;
   assign adel_push  = 1'b0;
`endif

   assign bus.inst_req  = issue_room && !misaligned;
   assign bus.inst_addr = pc_i;
   assign hs            = bus.inst_req && bus.inst_addr_ok;
   assign pc_en_o       = hs || adel_push;

   // Kill-cycle responses are always wrong-path.
   assign data_keep = data_ok && (drop_cnt_q == '0) && !kill_i;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32),
      .CNT_W (CNT_W)
   ) u_pc_q (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (1'b0),
      .push_i  (hs),
      .din_i   (pc_i),
      .pop_i   (data_ok),
      .dout_o  (pcq_head),
      .count_o (out_cnt)
   );

`ifdef FETCH_ADEL_EN
   fetch_entry_t push_entry;
   always_comb begin
      push_entry = '{inst: bus.inst_rdata, pc: pcq_head, adel: 1'b0};
      if (adel_push) begin
         push_entry = '{inst: FETCH_NOP, pc: pc_i, adel: 1'b1};
      end
   end
   assign fifo_din   = push_entry;
   assign head_entry = fetch_entry_t'(fifo_dout);
`else
   assign fifo_din   = {bus.inst_rdata, pcq_head};
   assign head_entry = '{inst: fifo_dout[63:32], pc: fifo_dout[31:0], adel: 1'b0};
`endif

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .CNT_W (CNT_W)
   ) u_inst_q (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (kill_i),
      .push_i  (data_keep || adel_push),
      .din_i   (fifo_din),
      .pop_i   (inst_valid_o && !stall_i),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt)
   );

   assign inst_valid_o  = (fifo_cnt != '0) && !kill_i;
   assign inst_o        = head_entry.inst;
   assign inst_pc_o     = head_entry.pc;
   assign inst_adel_o   = head_entry.adel;
   assign fetch_state_o = state_q;

   always_comb begin
      out_cnt_d  = out_cnt + CNT_W'(hs) - CNT_W'(data_ok);
      drop_cnt_d = drop_cnt_q;
      state_d    = state_q;
      // On a kill everything still outstanding after this edge is wrong-path,
      // including a request accepted in the kill cycle itself.
      if (kill_i) begin
         drop_cnt_d = out_cnt_d;
      end else if (data_ok && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - 1'b1;
      end
      case (state_q)
         RUN:     if (drop_cnt_d != '0) state_d = DRAIN;
         DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= '0;
         state_q    <= RUN;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         state_q    <= state_d;
      end
   end

   a_occupancy: assert property (@(posedge clk) disable iff (!rst)
      occupancy <= (CNT_W+1)'(DEPTH));
   a_drop_le_out: assert property (@(posedge clk) disable iff (!rst)
      drop_cnt_q <= out_cnt);
   a_no_orphan_data: assert property (@(posedge clk) disable iff (!rst)
      !(data_ok && (out_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Randomized bench for fetch_ctrl. The bench owns the PC
//               register and the memory; a reference model tracks the fetch
//               stream as queues of expected instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  pc_i;
   logic         pc_en_o;
   logic         kill_i;
   logic         stall_i;
   logic         inst_valid_o;
   logic [31:0]  inst_o;
   logic [31:0]  inst_pc_o;
   logic         inst_adel_o;
   fetch_state_e fetch_state_o;

   fetch_ctrl_if bus_if ();

   fetch_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .pc_en_o       (pc_en_o),
      .kill_i        (kill_i),
      .stall_i       (stall_i),
      .bus           (bus_if),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_adel_o   (inst_adel_o),
      .fetch_state_o (fetch_state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        keep;
      int          cyc;
   } pend_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   pend_t       pending[$];   // everything accepted by the bus, incl. wrong-path
   exp_t        expq[$];      // right-path fetches, in program order
   int          fifo_model;   // right-path instructions returned, not yet consumed
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          kills = 0;
   logic [31:0] pc_reg;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      pending.delete();
      expq.delete();
      fifo_model = 0;
      pc_reg     = 32'hbfc0_0000;
   endtask

   // One clock per iteration: drive at the falling edge, then evaluate the
   // model against what the DUT shows for the coming rising edge.
   task automatic run(input int n, input int p_kill, input int p_stall,
                      input int p_aok, input int p_dok);
      for (int k = 0; k < n; k++) begin
         int    occ;
         bit    exp_req, exp_valid, hs, drain;
         pend_t p;
         @(negedge clk);
         cyc++;
         pc_i                = pc_reg;
         kill_i              = ($urandom_range(99) < p_kill);
         stall_i             = ($urandom_range(99) < p_stall);
         bus_if.inst_addr_ok = ($urandom_range(99) < p_aok);
         if (pending.size() > 0 && pending[0].cyc < cyc && $urandom_range(99) < p_dok) begin
            bus_if.inst_data_ok = 1'b1;
            bus_if.inst_rdata   = mem_word(pending[0].pc);
         end else begin
            bus_if.inst_data_ok = 1'b0;
            bus_if.inst_rdata   = $urandom;
         end
         #1;
         occ       = pending.size() + fifo_model;
         exp_req   = (occ < DEPTH);
         exp_valid = (fifo_model > 0) && !kill_i;
         drain     = 1'b0;
         foreach (pending[i]) if (!pending[i].keep) drain = 1'b1;
         hs        = exp_req && bus_if.inst_addr_ok;
         check("inst_req", {31'b0, bus_if.inst_req}, {31'b0, exp_req});
         check("inst_valid", {31'b0, inst_valid_o}, {31'b0, exp_valid});
         check("pc_en", {31'b0, pc_en_o}, {31'b0, hs});
         check("state", 32'(fetch_state_o), drain ? 32'(DRAIN) : 32'(RUN));
         if (exp_req) check("inst_addr", bus_if.inst_addr, pc_reg);
         if (bus_if.inst_data_ok) begin
            p = pending.pop_front();
            if (p.keep && !kill_i) fifo_model++;
         end
         if (exp_valid && !stall_i) fifo_model--;
         if (kill_i) begin
            fifo_model = 0;
            expq.delete();
            foreach (pending[i]) pending[i].keep = 1'b0;
         end
         if (hs) begin
            pending.push_back('{pc_reg, !kill_i, cyc});
            if (!kill_i) expq.push_back('{mem_word(pc_reg), pc_reg});
         end
         if (kill_i) begin
            pc_reg = (kills == 0) ? 32'h8000_0180
                                  : 32'h8000_0000 + ($urandom_range(63) << 4);
            kills++;
         end else if (hs) begin
            pc_reg = pc_reg + 32'd4;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},    {31'b0, bus_if.inst_req}, 32'd0);
      check({tag, "_valid"},  {31'b0, inst_valid_o}, 32'd0);
      check({tag, "_pc_en"},  {31'b0, pc_en_o}, 32'd0);
      check({tag, "_inst"},   inst_o, 32'd0);
      check({tag, "_pc"},     inst_pc_o, 32'd0);
      check({tag, "_adel"},   {31'b0, inst_adel_o}, 32'd0);
   endtask

   // Monitor: consumes one expected instruction whenever decode takes one.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b1 && inst_valid_o === 1'b1 && stall_i === 1'b0) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_inst @cyc %0d: got pc %h, required no instruction", cyc, inst_pc_o);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("inst", inst_o, e.inst);
               check("inst_pc", inst_pc_o, e.pc);
               check("inst_adel", {31'b0, inst_adel_o}, 32'd0);
            end
         end
      end
   end

   initial begin
      rst                 = 1'b0;
      kill_i              = 1'b0;
      stall_i             = 1'b0;
      bus_if.inst_addr_ok = 1'b0;
      bus_if.inst_data_ok = 1'b0;
      bus_if.inst_rdata   = 32'h0;
      model_reset();
      pc_i                = pc_reg;
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
      check("reset_state", 32'(fetch_state_o), 32'(RUN));
      @(negedge clk);
      rst = 1'b1;

      run(40, 0, 0, 100, 100);     // streaming from the boot vector
      run(6, 0, 100, 100, 100);    // decode stalled
      run(20, 0, 0, 100, 100);     // release and drain
      run(3, 0, 0, 100, 0);        // build up in-flight requests
      run(1, 100, 0, 100, 100);    // kill with requests outstanding
      run(15, 0, 0, 100, 100);     // restart at the redirect target
      run(3000, 8, 30, 70, 60);    // random mix

      // Asynchronous reset between clock edges
      #2;
      rst                 = 1'b0;
      bus_if.inst_data_ok = 1'b0;
      bus_if.inst_addr_ok = 1'b0;
      kill_i              = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      pc_i = pc_reg;
      @(negedge clk);
      rst = 1'b1;
      run(20, 0, 0, 100, 100);
      run(400, 8, 30, 70, 60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
